stage2_window_gen: RTL
======================

# stage2_window_gen

Upstream feeder for the stage-2 convolution kernel. Accepts a raster-ordered stream of signed 20-bit feature-map pixels and builds a sliding 5x5 window with four internal line buffers plus a 5x5 shift register. For every pixel that completes a fully-inside window, it presents the 25 pixels packed in kernel order on a registered output. The output drives the stage-2 kernel `i_in_fmap` / `i_in_valid` directly.

## Interface
- `IBW`, default 20: pixel bit width; equals `ST2_Conv_IBW`.
- `KX`, default 5: window width.
- `KY`, default 5: window height.
- `IW`, default 12: input feature-map width in pixels.
- `IH`, default 12: input feature-map height in pixels.

- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `i_valid`, in, 1: `i_pixel` is valid this cycle. There is no backpressure; every valid pixel is consumed.
- `i_pixel`, in, signed `IBW`: pixel value in raster order (row-major, left to right, top to bottom).
- `o_valid`, out, 1: `o_window` holds a complete window this cycle. It is a one-cycle pulse per window.
- `o_window`, out, signed `KX*KY*IBW`: element (j,i) at bits `[(j*KX+i)*IBW +: IBW]`. j=0 is the top (oldest) row and i=0 is the left (oldest) column.
- `o_frame_done`, out, 1: one-cycle pulse, asserted together with `o_valid` for the last window of a frame.

## Operation
- **Position counters.** `col` counts 0..IW-1 and `row` counts 0..IH-1.
  - Both advance only on `i_valid`.
  - `col` wraps to 0 at IW-1 and increments `row`.
  - `row` wraps to 0 at IH-1 when `col` wraps, so the next pixel is (0,0) of the next frame.
  - There is no frame-start input; framing is purely count-based.
- **Line buffers.** There are KY-1 = 4 rows of IW entries, indexed by `col`. On a valid pixel at column c:
  - Read column c of the 4 stored rows, oldest first.
  - Shift the rows: row k takes row k+1's entry, and the newest row takes `i_pixel`.
  - Line-buffer storage is not reset.
- **Window register.** This is a 5x5 array. On a valid pixel:
  - Every row shifts left by one column (column 0 is discarded).
  - The new column 4 is {line rows 0..3 read at c, `i_pixel`}, with `i_pixel` at j=4.
  - The array holds its contents when `i_valid` is low.
- **Window valid.** Pixel (r,c) completes a window iff r ≥ KY-1 and c ≥ KX-1. The window's bottom-right element is that pixel.
  - This gives (IW-4)*(IH-4) = 64 windows per 12x12 frame.
  - Columns 0..3 of each row only prime the window; no output is produced for them.
- **Frame done.** `o_frame_done` is asserted for the pixel at (IH-1, IW-1).
- **Width.** There is no arithmetic on pixel data; values pass bit-exact, sign included.
- **Stale data.** Stale line-buffer or window contents from a previous frame or from before reset are never emitted. The r ≥ 4 / c ≥ 4 gating guarantees that every emitted element was written in the current frame.

## Timing
- **Reset values.** `o_valid`=0, `o_frame_done`=0, `o_window`=0. The counters `row`/`col` and the window array are also 0.
- **Latency.** A pixel accepted on the edge ending cycle N produces `o_valid`=1 with the updated window during cycle N+1. `o_window` is registered.
- **Bubbles.**
  - `i_valid` low for any number of cycles leaves all state and `o_window` unchanged.
  - `o_valid` and `o_frame_done` drop to 0 in that case.
- **Back-to-back pixels.** Up to IW-4 consecutive `o_valid` cycles occur per row, and one pixel is accepted per cycle at full rate.
- **Frame wrap.** The first pixel of frame k+1 may directly follow the last pixel of frame k. `o_frame_done` of frame k and the priming of frame k+1 do not interfere.
- **Reset mid-frame.**
  - Outputs and counters clear immediately (asynchronously).
  - The first valid pixel after reset deasserts is treated as (0,0).
  - No window is emitted until row 4, column 4 of the new frame.
- **End-to-end.** Stage-2 kernel output appears 2 further cycles after `o_valid`.

## Test plan
- **Basic window.** Stream one 12x12 frame continuously with pixel(r,c) = r*16+c.
  - First `o_valid` comes 1 cycle after pixel index 52, i.e. (4,4).
  - That window has element (0,0)=0x00, (0,4)=0x04, (4,0)=0x40 and (4,4)=0x44.
  - Exactly 64 `o_valid` pulses occur.
  - `o_frame_done` coincides with the window whose (4,4) element is 0xBB.
- **Random bubbles.** Repeat the basic frame with `i_valid` randomly low about 40% of cycles.
  - The same 64 windows appear in the same order.
  - No pulse appears during a bubble.
  - `o_window` holds its value between pulses.
- **Signed pass-through.** Pixels alternate between -524288 (0x80000) and 524287.
  - Every window element matches the source bit-exact.
  - No sign corruption in the packed bus.
- **Back-to-back frames.** Send frame A with value r*16+c and then frame B with value 0x7F000+r*16+c, with no gap.
  - 128 windows total and 2 `o_frame_done` pulses.
  - The first window of B has (0,0)=0x7F000, and no A value appears in any B window.
- **Reset mid-frame.** Assert `reset_n`=0 after pixel (6,7) of a frame, then restart a fresh frame.
  - Outputs read 0 during reset.
  - After release, the first `o_valid` comes only after new pixel (4,4), with window contents from the new frame only.
- **Row-edge gating.** In the basic frame, check that no `o_valid` occurs for any pixel with c<4, and check a window straddling a row boundary.
  - The window at pixel (5,4) has element (0,0) = 0x10.

Source files
------------

// File: rtl/stage2_window_gen.sv
// stage2_window_gen: raster pixel stream to sliding KYxKX window.
// Four line buffers plus a window shift array feed a registered packed output.
module stage2_window_gen #(
  parameter int IBW = 20,
  parameter int KX  = 5,
  parameter int KY  = 5,
  parameter int IW  = 12,
  parameter int IH  = 12
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_valid,
  input  logic signed [IBW-1:0]         i_pixel,
  output logic                          o_valid,
  output logic signed [KX*KY*IBW-1:0]   o_window,
  output logic                          o_frame_done
);

  localparam int CW = $clog2(IW);
  localparam int RW = $clog2(IH);
  localparam int LB = KY - 1;

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [IBW-1:0] lb_q  [LB][IW];
  logic [IBW-1:0] lb_rd [LB];
  logic [IBW-1:0] win_q [KY][KX];
  logic [IBW-1:0] win_d [KY][KX];
  logic [KX*KY*IBW-1:0] pack_d;
  logic fire;
  logic last;

  // Read the stored rows at the current column, oldest first.
  always_comb begin
    for (int k = 0; k < LB; k++) begin
      lb_rd[k] = lb_q[k][col_q];
    end
  end

  // Window completion and end-of-frame detection.
  always_comb begin
    fire = i_valid
         && (row_q >= RW'(KY-1))
         && (col_q >= CW'(KX-1));
    last = i_valid
         && (row_q == RW'(IH-1))
         && (col_q == CW'(IW-1));
  end

  // Raster position advance; row wraps with the last column.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_valid) begin
      if (col_q == CW'(IW-1)) begin
        col_d = '0;
        if (row_q == RW'(IH-1)) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Shift the window left and load the new right column.
  always_comb begin
    win_d = win_q;
    if (i_valid) begin
      for (int j = 0; j < KY; j++) begin
        for (int i = 0; i < KX-1; i++) begin
          win_d[j][i] = win_q[j][i+1];
        end
      end
      for (int j = 0; j < LB; j++) begin
        win_d[j][KX-1] = lb_rd[j];
      end
      win_d[KY-1][KX-1] = i_pixel;
    end
  end

  // Pack the next window in kernel order.
  always_comb begin
    pack_d = '0;
    for (int j = 0; j < KY; j++) begin
      for (int i = 0; i < KX; i++) begin
        pack_d[(j*KX+i)*IBW +: IBW] = win_d[j][i];
      end
    end
  end

  // Line buffers: rotate rows at the current column, no reset needed.
  always_ff @(posedge clk) begin
    if (i_valid) begin
      for (int k = 0; k < LB-1; k++) begin
        lb_q[k][col_q] <= lb_q[k+1][col_q];
      end
      lb_q[LB-1][col_q] <= i_pixel;
    end
  end

  // Counters, window array and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_window     <= '0;
      for (int j = 0; j < KY; j++) begin
        for (int i = 0; i < KX; i++) begin
          win_q[j][i] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      o_valid      <= fire;
      o_frame_done <= last;
      if (fire) begin
        o_window <= pack_d;
      end
    end
  end

endmodule
